psum_col_accumulator: RTL
=========================

PSUM_COL_ACCUMULATOR -- requirements
Module: psum_col_accumulator

Interface
REQ-001 SHALL have parameter ROWS, default 64, psum rows per output tile (buffer depth).
REQ-002 SHALL have parameter LANE_W, default `SYSTOLIC_PSUM_WIDTH/`TIME_STEPS (20), input lane width.
REQ-003 SHALL have parameter ACC_W, default LANE_W+4 (24), accumulator lane width.
REQ-004 SHALL have port s_clk, input, 1, sole clock; all state changes on rising edge.
REQ-005 SHALL have port s_rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, pulse that latches cfg and begins a tile.
REQ-007 SHALL have ports cfg_rows (input, clog2(ROWS)+1, rows) and cfg_tiles (input, 8, K-tiles to sum).
REQ-008 SHALL have port in_psum_valid, input, 1, bottom-PE psum valid.
REQ-009 SHALL have port in_psum_data, input, TIME_STEPS*LANE_W, packed signed lanes, T0 in LSBs.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, TIME_STEPS*ACC_W, same lane order).
REQ-011 SHALL have outputs busy, done (1-cycle pulse), sat_flag (sticky), drop_err (sticky), each 1 bit.

Function
REQ-012 SHALL implement FSM IDLE -> ACCUM -> DRAIN -> IDLE.
REQ-013 IDLE: start latches cfg, clears row_cnt, tile_cnt, sat_flag, drop_err; next state ACCUM.
REQ-014 cfg_rows of 0 or >ROWS SHALL be treated as ROWS; cfg_tiles of 0 as 1.
REQ-015 ACCUM: each in_psum_valid cycle processes one row at buf[row_cnt]; no backpressure toward array.
REQ-016 On tile_cnt==0, row write = sign-extended input lanes; otherwise lane-wise buf + input.
REQ-017 Lane sums SHALL saturate signed to ACC_W (24-bit: +8388607 / -8388608); any saturation sets sat_flag.
REQ-018 row_cnt wraps to 0 after cfg_rows-1 and tile_cnt increments; after last row of tile cfg_tiles-1, next state DRAIN.
REQ-019 in_psum_valid in IDLE or DRAIN SHALL be discarded and set drop_err.
REQ-020 DRAIN: out_valid registered, asserted the cycle after entry; out_data = buf[rd_cnt].
REQ-021 out_data SHALL be held stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready, rd_cnt increments; after row cfg_rows-1, out_valid drops, done pulses, FSM returns IDLE.
REQ-023 start outside IDLE SHALL be ignored; start and last handshake in same cycle: start ignored.
REQ-024 busy SHALL be high in ACCUM and DRAIN.
REQ-025 Write-to-read latency: a row written in cycle N is readable in cycle N+1 (no bypass needed; rows never re-read within one pass).

Reset
REQ-026 s_rst low SHALL asynchronously force IDLE, counters 0, out_valid 0, out_data 0, done 0, busy 0, sat_flag 0, drop_err 0.
REQ-027 Buffer contents SHALL NOT be reset; reset mid-ACCUM/DRAIN abandons the tile, no done pulse.

Structure
REQ-028 `SYSTOLIC_PSUM_WIDTH, `TIME_STEPS and new `PSUM_ACC_WIDTH SHALL live in shared hyper_para.v; FSM encoding local.
REQ-029 Lane add/saturate SHALL be one sub-module psum_lane_sat_add, instantiated TIME_STEPS times.
REQ-030 Buffer SHALL be a single-port-write, single-port-read inferable memory of ROWS x TIME_STEPS*ACC_W.

Verification
REQ-031 cfg_rows=4, cfg_tiles=1, inputs lanes {1,2,3,4}+r, out_ready=1 -> 4 outputs equal to sign-extended inputs, done one cycle after last handshake.
REQ-032 cfg_rows=2, cfg_tiles=3, all lanes -5 each tile -> outputs all lanes -15, sat_flag 0.
REQ-033 cfg_tiles=2, lane T2 = 0x7FFFF (524287) per tile into ACC_W=20 build -> T2 saturates to 524287, sat_flag 1.
REQ-034 DRAIN with out_ready toggling 1,0,0,1 -> out_data unchanged during stalls, exactly cfg_rows handshakes.
REQ-035 in_psum_valid during DRAIN -> drop_err 1, outputs unaffected; next start clears drop_err.
REQ-036 s_rst low mid-ACCUM -> immediate IDLE, busy 0, no done; fresh tile afterwards yields correct sums.

Source files
------------

// File: rtl/psum_col_accumulator_pkg.sv
// Shared systolic-array widths and small helpers for the psum column accumulator.
package psum_col_accumulator_pkg;

  localparam int SYSTOLIC_PSUM_WIDTH = 80;
  localparam int TIME_STEPS          = 4;
  localparam int PSUM_ACC_WIDTH      = SYSTOLIC_PSUM_WIDTH / TIME_STEPS + 4;

  // A tile count of zero means a single K-tile.
  function automatic logic [7:0] tiles_last(input logic [7:0] cfg_tiles);
    return (cfg_tiles == 8'd0) ? 8'd0 : cfg_tiles - 8'd1;
  endfunction

endpackage

// File: rtl/psum_col_accumulator_lane_sat_add.sv
// One accumulator lane: sign-extends the incoming psum and adds it to the
// buffered value (or overwrites on the first K-tile), saturating to ACC_W.
module psum_lane_sat_add #(
  parameter int LANE_W = 20,
  parameter int ACC_W  = 24
) (
  input  logic                     i_first,
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic signed [LANE_W-1:0] i_lane,
  output logic signed [ACC_W-1:0]  o_sum,
  output logic                     o_sat
);

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] w_acc_ext;
  logic [ACC_W:0] w_lane_ext;
  logic [ACC_W:0] w_sum;

  assign w_acc_ext  = i_first ? '0 : {i_acc[ACC_W-1], i_acc};
  assign w_lane_ext = {{(ACC_W+1-LANE_W){i_lane[LANE_W-1]}}, i_lane};
  assign w_sum      = w_acc_ext + w_lane_ext;

  // One guard bit is enough: overflow shows up as the two top bits disagreeing.
  assign o_sat = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign o_sum = !o_sat ? w_sum[ACC_W-1:0] : (w_sum[ACC_W] ? SAT_MIN : SAT_MAX);

endmodule

// File: rtl/psum_col_accumulator.sv
// Column accumulator: sums K-tiles of bottom-PE psums into a row buffer, then
// drains the finished tile over a valid/ready output port.
module psum_col_accumulator
  import psum_col_accumulator_pkg::*;
#(
  parameter int ROWS   = 64,
  parameter int LANE_W = SYSTOLIC_PSUM_WIDTH / TIME_STEPS,
  parameter int ACC_W  = LANE_W + 4
) (
  input  logic                           s_clk,
  input  logic                           s_rst,
  input  logic                           start,
  input  logic [$clog2(ROWS):0]          cfg_rows,
  input  logic [7:0]                     cfg_tiles,
  input  logic                           in_psum_valid,
  input  logic [TIME_STEPS*LANE_W-1:0]   in_psum_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [TIME_STEPS*ACC_W-1:0]    out_data,
  output logic                           busy,
  output logic                           done,
  output logic                           sat_flag,
  output logic                           drop_err
);

  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(ROWS) + 1;
  localparam int DW = TIME_STEPS * ACC_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_rows_m1, r_row_cnt, r_rd_cnt;
  logic [7:0]    r_tiles_m1, r_tile_cnt;
  logic          r_out_valid, r_done, r_sat_flag, r_drop_err;
  logic [DW-1:0] r_out_data;
  logic [DW-1:0] r_buf [ROWS];

  logic [AW-1:0]         w_rows_m1_cfg, w_drain_addr, w_rd_addr;
  logic [DW-1:0]         w_rd_row, w_wr_row;
  logic [TIME_STEPS-1:0] w_lane_sat;
  logic                  w_acc_wr, w_first_tile, w_last_row;

  always_comb begin
    w_rows_m1_cfg = AW'(cfg_rows - 1'b1);
    if (cfg_rows == '0 || cfg_rows > CW'(ROWS)) w_rows_m1_cfg = AW'(ROWS - 1);
  end

  // Single read port: row under accumulation in ACCUM, next row to present in DRAIN.
  assign w_drain_addr = r_out_valid ? r_rd_cnt + 1'b1 : '0;
  assign w_rd_addr    = (r_state == S_ACCUM) ? r_row_cnt : w_drain_addr;
  assign w_rd_row     = r_buf[w_rd_addr];
  assign w_acc_wr     = (r_state == S_ACCUM) && in_psum_valid;
  assign w_first_tile = (r_tile_cnt == 8'd0);
  assign w_last_row   = (r_row_cnt == r_rows_m1);

  for (genvar t = 0; t < TIME_STEPS; t++) begin : g_lane
    psum_lane_sat_add #(.LANE_W(LANE_W), .ACC_W(ACC_W)) u_lane (
      .i_first (w_first_tile),
      .i_acc   (w_rd_row[t*ACC_W +: ACC_W]),
      .i_lane  (in_psum_data[t*LANE_W +: LANE_W]),
      .o_sum   (w_wr_row[t*ACC_W +: ACC_W]),
      .o_sat   (w_lane_sat[t])
    );
  end

  always_ff @(posedge s_clk) begin
    if (w_acc_wr) r_buf[r_row_cnt] <= w_wr_row;
  end

  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_state     <= S_IDLE;
      r_rows_m1   <= '0;
      r_row_cnt   <= '0;
      r_rd_cnt    <= '0;
      r_tiles_m1  <= '0;
      r_tile_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_sat_flag  <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rows_m1  <= w_rows_m1_cfg;
            r_tiles_m1 <= tiles_last(cfg_tiles);
            r_row_cnt  <= '0;
            r_tile_cnt <= '0;
            r_sat_flag <= 1'b0;
            r_drop_err <= 1'b0;
            r_state    <= S_ACCUM;
          end
          if (in_psum_valid) r_drop_err <= 1'b1;
        end
        S_ACCUM: begin
          if (in_psum_valid) begin
            if (|w_lane_sat) r_sat_flag <= 1'b1;
            if (w_last_row) begin
              r_row_cnt <= '0;
              if (r_tile_cnt == r_tiles_m1) begin
                r_rd_cnt <= '0;
                r_state  <= S_DRAIN;
              end else begin
                r_tile_cnt <= r_tile_cnt + 8'd1;
              end
            end else begin
              r_row_cnt <= r_row_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (in_psum_valid) r_drop_err <= 1'b1;
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rd_row;
            r_rd_cnt    <= '0;
          end else if (out_ready) begin
            if (r_rd_cnt == r_rows_m1) begin
              r_out_valid <= 1'b0;
              r_rd_cnt    <= '0;
              r_done      <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_rd_cnt   <= r_rd_cnt + 1'b1;
              r_out_data <= w_rd_row;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state == S_ACCUM) || (r_state == S_DRAIN);
  assign done      = r_done;
  assign sat_flag  = r_sat_flag;
  assign drop_err  = r_drop_err;

endmodule
